gray_rx: RTL and testbench

Receive-side companion to the 3-bit Gray counter. It samples a Gray-coded count whenever the enable input is high, decodes it to binary, and checks that each new value is either the previous value or exactly one step ahead. It counts wrap-arounds from the maximum value back to zero and latches a sticky error on any illegal transition. It sits at the consumer end of a Gray-counter link, for example across a clock-domain boundary or on a bench monitor, and checks the counter's output sequence and overflow behaviour.

---
 rtl/gray_rx_if.sv | 14 +
 rtl/gray_rx.sv | 65 ++++++
 tb/tb_gray_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gray_rx_if.sv
// gray_rx_if: sample/clear inputs and decoded status outputs of the Gray-count receiver
interface gray_rx_if #(parameter int W = 3, parameter int CW = 8);
  logic          en;
  logic          clear;
  logic [W-1:0]  gray_in;
  logic [W-1:0]  binary;
  logic          valid;
  logic          wrap;
  logic [CW-1:0] wrap_count;
  logic          error;
  logic          locked;
  modport master(output en, clear, gray_in, input binary, valid, wrap, wrap_count, error, locked);
  modport slave(input en, clear, gray_in, output binary, valid, wrap, wrap_count, error, locked);
endinterface

// File: rtl/gray_rx.sv
// gray_rx: decodes sampled Gray counts, checks single-step legality and counts wraps
module gray_rx #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input logic      clk,
  input logic      rst_n,
  gray_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
  state_t        state, state_n;
  logic [W-1:0]  d, prev, prev_n, inc;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid, valid_n, wrap, wrap_n, error, error_n, bad;
  for (genvar i = 0; i < W; i++) begin : g_dec
    assign d[i] = ^(bus.gray_in >> i);
  end
  assign inc = prev + 1'b1;
  assign bad = d != prev && d != inc;
  // Next state and outputs; a clear discards any sample offered in the same cycle
  always_comb begin
    state_n = state;
    prev_n  = prev;
    cnt_n   = cnt;
    error_n = error;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      error_n = 1'b0;
    end else if (bus.en) begin
      prev_n  = d;
      valid_n = 1'b1;
      wrap_n  = state == TRACK && prev == '1 && d == '0;
      cnt_n   = cnt + CW'(wrap_n && cnt != '1);
      error_n = error | (state == TRACK && bad);
      state_n = state == IDLE ? TRACK : (state == TRACK && bad) ? ERROR : state;
    end
  end
  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev  <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      wrap  <= wrap_n;
      error <= error_n;
    end
  end
  assign bus.binary     = prev;
  assign bus.valid      = valid;
  assign bus.wrap       = wrap;
  assign bus.wrap_count = cnt;
  assign bus.error      = error;
  assign bus.locked     = state == TRACK;
endmodule

// File: tb/tb_gray_rx.sv
// tb_gray_rx: vector table plus scoreboard checks of gray_rx (CW=8 and a CW=2 saturation copy)
module tb_gray_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_step = 0;
  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] g;
    logic [2:0] bin;
    logic       vld;
    logic       wr;
    int         wc;
    logic       er;
    logic       lk;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  gray_rx_if #(.W(3), .CW(8)) bus();
  gray_rx_if #(.W(3), .CW(2)) bus2();
  gray_rx #(.W(3), .CW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  gray_rx #(.W(3), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic en, logic clr, logic [2:0] g, logic [2:0] bin, logic vld, logic wr, int wc, logic er, logic lk);
    vec_t t;
    t.en = en; t.clr = clr; t.g = g; t.bin = bin; t.vld = vld; t.wr = wr; t.wc = wc; t.er = er; t.lk = lk;
    return t;
  endfunction
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  task automatic drive(input logic en, input logic clr, input logic [2:0] g);
    bus.en = en; bus.clear = clr; bus.gray_in = g;
    bus2.en = en; bus2.clear = clr; bus2.gray_in = g;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_binary"}, 32'(bus.binary), 0);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_wrap"}, 32'(bus.wrap), 0);
    chk({tag, "_wrap_count"}, 32'(bus.wrap_count), 0);
    chk({tag, "_error"}, 32'(bus.error), 0);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_wrap_count2"}, 32'(bus2.wrap_count), 0);
    chk({tag, "_binary2"}, 32'(bus2.binary), 0);
  endtask
  task automatic step(input vec_t t);
    vec_t e;
    string s;
    @(negedge clk);
    drive(t.en, t.clr, t.g);
    sb.push_back(t);
    @(posedge clk);
    #1;
    n_step++;
    s = $sformatf("step%0d", n_step);
    if (sb.size() == 0) begin
      chk({s, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({s, "_binary"}, 32'(bus.binary), 32'(e.bin));
      chk({s, "_valid"}, 32'(bus.valid), 32'(e.vld));
      chk({s, "_wrap"}, 32'(bus.wrap), 32'(e.wr));
      chk({s, "_wrap_count"}, 32'(bus.wrap_count), 32'(e.wc));
      chk({s, "_error"}, 32'(bus.error), 32'(e.er));
      chk({s, "_locked"}, 32'(bus.locked), 32'(e.lk));
      chk({s, "_wrap2"}, 32'(bus2.wrap), 32'(e.wr));
      chk({s, "_wrap_count2"}, 32'(bus2.wrap_count), 32'(e.wc > 3 ? 3 : e.wc));
    end
  endtask
  task automatic run_up(input int from, input int to, input int wc0);
    for (int k = from; k <= to; k++) begin
      logic [2:0] b;
      b = 3'(k % 8);
      step(mk(1, 0, b ^ (b >> 1), b, 1, k == 8, wc0 + (k == 8 ? 1 : 0), 0, 1));
    end
  endtask
  initial begin
    drive(0, 0, 3'b000);
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    // full sequence 0..7,0
    tbl.push_back(mk(1, 0, 3'b000, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b011, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b110, 4, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b111, 5, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b101, 6, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b100, 7, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b000, 0, 1, 1, 1, 0, 1));
    // enable gaps and a repeat
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b011, 2, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'b111, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'b100, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b011, 2, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 3, 1, 0, 1, 0, 1));
    // walk to 1 through a second wrap, then jump 1->3 and move around in ERROR
    tbl.push_back(mk(1, 0, 3'b110, 4, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b111, 5, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b101, 6, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b100, 7, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b000, 0, 1, 1, 2, 0, 1));
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 0, 2, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 3, 1, 0, 2, 1, 0));
    tbl.push_back(mk(1, 0, 3'b100, 7, 1, 0, 2, 1, 0));
    tbl.push_back(mk(1, 0, 3'b000, 0, 1, 0, 2, 1, 0));
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 3'b001, 1, 0, 0, 2, 1, 0));
    // clear colliding with a sample, then resync
    tbl.push_back(mk(1, 1, 3'b110, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b110, 4, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b111, 5, 1, 0, 0, 0, 1));
    // backward step from a fresh lock
    tbl.push_back(mk(0, 1, 3'b000, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b011, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'b000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b000, 0, 1, 0, 0, 0, 1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    foreach (tbl[i]) step(tbl[i]);
    // four full cycles: CW=2 copy saturates at 3
    for (int c = 0; c < 4; c++) run_up(1, 8, c);
    step(mk(0, 0, 3'b000, 0, 0, 0, 4, 0, 1));
    // mid-stream asynchronous reset at binary 5, two wraps
    step(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 3'b000, 0, 1, 0, 0, 0, 1));
    run_up(1, 8, 0);
    run_up(1, 8, 1);
    run_up(1, 5, 2);
    @(negedge clk);
    drive(0, 0, 3'b000);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(mk(1, 0, 3'b101, 6, 1, 0, 0, 0, 1));
    step(mk(1, 0, 3'b100, 7, 1, 0, 0, 0, 1));
    step(mk(0, 0, 3'b100, 7, 0, 0, 0, 0, 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
